// File: rtl/cpu_multicycle.sv
// ============================================================================
// Module : cpu_multicycle
// Desc   : Parametrised multicycle CPU core with Z/C flags, relative branches,
//          HALT and req/ack handshakes to instruction and data memories.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_multicycle #(
    parameter int DW   = 16,
    parameter int NREG = 4,
    parameter int AW   = 16
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [15:0]   imem_rdata,
    input  logic          imem_ack,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic [AW-1:0] o_ip,
    output logic [15:0]   o_ir,
    output logic [DW-1:0] o_reg0,
    output logic [1:0]    o_flags,
    output logic [1:0]    o_state,
    output logic          halted
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [3:0] c_OP_LDI  = 4'h1;
    localparam logic [3:0] c_OP_MOV  = 4'h2;
    localparam logic [3:0] c_OP_ADD  = 4'h3;
    localparam logic [3:0] c_OP_SUB  = 4'h4;
    localparam logic [3:0] c_OP_AND  = 4'h5;
    localparam logic [3:0] c_OP_OR   = 4'h6;
    localparam logic [3:0] c_OP_XOR  = 4'h7;
    localparam logic [3:0] c_OP_SHL  = 4'h8;
    localparam logic [3:0] c_OP_SHR  = 4'h9;
    localparam logic [3:0] c_OP_LD   = 4'hA;
    localparam logic [3:0] c_OP_ST   = 4'hB;
    localparam logic [3:0] c_OP_JZ   = 4'hC;
    localparam logic [3:0] c_OP_JC   = 4'hD;
    localparam logic [3:0] c_OP_JMP  = 4'hE;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] ip_q;
    logic [15:0]   ir_q;
    logic          c_q;
    logic          z_q;
    logic [DW-1:0] rf_q [NREG];

    logic [3:0]    op;
    logic [IW-1:0] rd;
    logic [IW-1:0] rs;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res_d;
    logic          c_d;
    logic          z_d;
    logic [AW-1:0] br_target;

    assign op = ir_q[15:12];
    assign rd = ir_q[8 +: IW];
    assign rs = ir_q[4 +: IW];
    assign a  = rf_q[rd];
    assign b  = rf_q[rs];

    // ip already points past the branch, so the target is ip + sext(imm8)
    assign br_target = ip_q + AW'($signed(ir_q[7:0]));

    always_comb begin
        res_d = a;
        c_d   = 1'b0;
        case (op)
            c_OP_ADD: {c_d, res_d} = {1'b0, a} + {1'b0, b};
            c_OP_SUB: {c_d, res_d} = {1'b0, a} - {1'b0, b};
            c_OP_AND: res_d = a & b;
            c_OP_OR:  res_d = a | b;
            c_OP_XOR: res_d = a ^ b;
            c_OP_SHL: {c_d, res_d} = {a, 1'b0};
            c_OP_SHR: {res_d, c_d} = {1'b0, a};
            default:  res_d = a;
        endcase
        z_d = (res_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ip_q    <= '0;
            ir_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        ip_q    <= ip_q + AW'(1);
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    case (op)
                        c_OP_LDI: rf_q[rd] <= DW'(ir_q[7:0]);
                        c_OP_MOV: rf_q[rd] <= b;
                        c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
                        c_OP_XOR, c_OP_SHL, c_OP_SHR: begin
                            rf_q[rd] <= res_d;
                            c_q      <= c_d;
                            z_q      <= z_d;
                        end
                        c_OP_LD, c_OP_ST: state_q <= S_MEM;
                        c_OP_JZ: if (z_q) ip_q <= br_target;
                        c_OP_JC: if (c_q) ip_q <= br_target;
                        c_OP_JMP: ip_q <= br_target;
                        c_OP_HALT: state_q <= S_HALT;
                        default: state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (op == c_OP_LD) begin
                            rf_q[rd] <= dmem_rdata;
                        end
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Requests decode the registered state; address and data come from
    // registers that cannot change until the access completes.
    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = ip_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = (state_q == S_MEM) && (op == c_OP_ST);
    assign dmem_addr  = AW'(b);
    assign dmem_wdata = a;

    assign o_ip    = ip_q;
    assign o_ir    = ir_q;
    assign o_reg0  = rf_q[0];
    assign o_flags = {c_q, z_q};
    assign o_state = state_q;
    assign halted  = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_cpu_multicycle.sv
// ============================================================================
// Module : tb_cpu_multicycle
// Desc   : Self-checking bench for cpu_multicycle against an instruction-level
//          reference model with wait-state memory responders.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_multicycle;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [15:0] o_ip;
    logic [15:0] o_ir;
    logic [15:0] o_reg0;
    logic [1:0]  o_flags;
    logic [1:0]  o_state;
    logic        halted;

    cpu_multicycle #(.DW(16), .NREG(4), .AW(16)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .o_ip(o_ip), .o_ir(o_ir), .o_reg0(o_reg0), .o_flags(o_flags), .o_state(o_state),
        .halted(halted)
    );

    always #5 clk = ~clk;

    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    logic [31:0] st_q [$];
    int iwait = 0;
    int dwait = 0;
    int icnt = 0;
    int dcnt = 0;

    int          m_reg [4];
    int          m_ip;
    bit          m_z, m_c, m_halt;
    logic [15:0] m_dmem [256];

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Instruction memory: ack after iwait extra cycles; spurious acks otherwise
    always @(negedge clk) begin
        if (reset) begin
            icnt       = 0;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = 16'($urandom);
        end else if (imem_req) begin
            if (icnt >= iwait) begin
                imem_ack   = 1'b1;
                imem_rdata = imem[imem_addr[7:0]];
                icnt       = 0;
            end else begin
                imem_ack = 1'b0;
                icnt++;
            end
        end else begin
            icnt       = 0;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = 16'($urandom);
        end
    end

    always @(negedge clk) begin
        if (!reset && dmem_req) begin
            if (dcnt >= dwait) begin
                dmem_ack = 1'b1;
                dcnt     = 0;
                if (dmem_we) begin
                    dmem[dmem_addr[7:0]] = dmem_wdata;
                    st_q.push_back({dmem_addr, dmem_wdata});
                end else begin
                    dmem_rdata = dmem[dmem_addr[7:0]];
                end
            end else begin
                dmem_ack = 1'b0;
                dcnt++;
            end
        end else begin
            dcnt       = 0;
            dmem_ack   = reset ? 1'b0 : 1'($urandom_range(0, 1));
            dmem_rdata = 16'($urandom);
        end
    end

    function automatic logic [15:0] enc(input int op, input int rd, input int x);
        return {4'(op), 4'(rd), 8'(x)};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        m_ip = 0; m_z = 0; m_c = 0; m_halt = 0;
    endtask

    // Executes one instruction architecturally and predicts its cycle cost
    task automatic model_step(output int exp_cyc, output bit st_exp, output logic [31:0] st_val);
        logic [15:0] ins;
        int op, rd, rs, imm, a, b, r, off, nip;
        bit wf, taken;
        ins = imem[m_ip % 256];
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:8]) % 4;
        rs  = int'(ins[7:4]) % 4;
        imm = int'(ins[7:0]);
        off = (imm >= 128) ? imm - 256 : imm;
        a = m_reg[rd]; b = m_reg[rs]; r = 0;
        wf = 0; taken = 0; st_exp = 0; st_val = '0;
        exp_cyc = 2 + iwait;
        case (op)
            1:  m_reg[rd] = imm;
            2:  m_reg[rd] = b;
            3:  begin r = a + b; m_c = (r >= 65536); r = r % 65536; wf = 1; end
            4:  begin m_c = (a < b); r = (a - b + 65536) % 65536; wf = 1; end
            5:  begin r = a & b; m_c = 0; wf = 1; end
            6:  begin r = a | b; m_c = 0; wf = 1; end
            7:  begin r = a ^ b; m_c = 0; wf = 1; end
            8:  begin m_c = (a >= 32768); r = (a * 2) % 65536; wf = 1; end
            9:  begin m_c = ((a % 2) == 1); r = a / 2; wf = 1; end
            10: begin m_reg[rd] = int'(m_dmem[b % 256]); exp_cyc += 1 + dwait; end
            11: begin
                m_dmem[b % 256] = 16'(a);
                st_exp = 1;
                st_val = {16'(b), 16'(a)};
                exp_cyc += 1 + dwait;
            end
            12: taken = m_z;
            13: taken = m_c;
            14: taken = 1;
            15: m_halt = 1;
            default: ;
        endcase
        if (wf) begin
            m_reg[rd] = r;
            m_z = (r == 0);
        end
        nip = m_ip + 1;
        if (taken) nip += off;
        m_ip = (nip + 65536) % 65536;
    endtask

    // Run one DUT instruction from FETCH and compare with the model
    task automatic exec_and_check(input string tag);
        int exp_cyc, cyc;
        bit left, st_exp;
        logic [31:0] stv;
        logic [15:0] ins;
        ins = imem[m_ip % 256];
        model_step(exp_cyc, st_exp, stv);
        cyc = 0; left = 0;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (o_state != 2'd0) left = 1;
            else if (left) break;
            if (o_state == 2'd3) break;
        end
        chk_cnt++;
        if (cyc !== exp_cyc) $display("FAIL %s cycles: got %0d expected %0d", tag, cyc, exp_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (o_ir !== ins) $display("FAIL %s ir: got %h expected %h", tag, o_ir, ins);
        else pass_cnt++;
        chk_cnt++;
        if (o_ip !== 16'(m_ip)) $display("FAIL %s ip: got %h expected %h", tag, o_ip, 16'(m_ip));
        else pass_cnt++;
        chk_cnt++;
        if (o_reg0 !== 16'(m_reg[0])) $display("FAIL %s reg0: got %h expected %h", tag, o_reg0, 16'(m_reg[0]));
        else pass_cnt++;
        chk_cnt++;
        if (o_flags !== {m_c, m_z}) $display("FAIL %s flags: got %b expected %b", tag, o_flags, {m_c, m_z});
        else pass_cnt++;
        chk_cnt++;
        if (halted !== m_halt) $display("FAIL %s halted: got %b expected %b", tag, halted, m_halt);
        else pass_cnt++;
        chk_cnt++;
        if (st_q.size() !== int'(st_exp) || (st_exp && st_q[0] !== stv))
            $display("FAIL %s store: got %0d entries head %h expected %0d entries %h",
                     tag, st_q.size(), (st_q.size() > 0) ? st_q[0] : 32'h0, int'(st_exp), stv);
        else pass_cnt++;
        st_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        st_q.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (imem_req !== 1'b1 || imem_addr !== 16'h0 || o_ip !== 16'h0)
                $display("FAIL reset_fetch: got req=%b addr=%h ip=%h expected 1/0000/0000", imem_req, imem_addr, o_ip);
            else pass_cnt++;
        end
        chk_cnt++;
        if (o_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", o_state); else pass_cnt++;
        chk_cnt++;
        if (dmem_req !== 1'b0) $display("FAIL reset_dmem_req: got %b expected 0", dmem_req); else pass_cnt++;
        chk_cnt++;
        if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else pass_cnt++;
        chk_cnt++;
        if (o_flags !== 2'b00) $display("FAIL reset_flags: got %b expected 00", o_flags); else pass_cnt++;
        chk_cnt++;
        if (o_reg0 !== 16'h0 || o_ir !== 16'h0) $display("FAIL reset_regs: got r0=%h ir=%h expected 0/0", o_reg0, o_ir);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int cyc;
        bit req_seen;
        clear_imem();
        imem[0] = enc(1, 0, 5);
        imem[1] = enc(1, 1, 3);
        imem[2] = enc(3, 0, 1 << 4);
        imem[3] = enc(15, 0, 0);
        iwait = 0; dwait = 0;
        do_reset();
        cyc = 0;
        while (cyc < 50 && halted !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk_cnt++;
        if (cyc !== 8) $display("FAIL basic_halt_latency: got %0d expected 8", cyc); else pass_cnt++;
        chk_cnt++;
        if (o_reg0 !== 16'h0008) $display("FAIL basic_r0: got %h expected 0008", o_reg0); else pass_cnt++;
        chk_cnt++;
        if (o_flags !== 2'b00) $display("FAIL basic_flags: got %b expected 00", o_flags); else pass_cnt++;
        chk_cnt++;
        if (o_ip !== 16'h0004) $display("FAIL basic_ip: got %h expected 0004", o_ip); else pass_cnt++;
        req_seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (imem_req !== 1'b0 || dmem_req !== 1'b0) req_seen = 1;
        end
        chk_cnt++;
        if (req_seen) $display("FAIL basic_no_req_after_halt: got request expected none"); else pass_cnt++;
    endtask

    task automatic test_carry();
        clear_imem();
        imem[0] = enc(1, 0, 0);
        imem[1] = enc(1, 1, 1);
        imem[2] = enc(4, 0, 1 << 4);
        imem[3] = enc(3, 0, 1 << 4);
        imem[4] = enc(9, 1, 0);
        imem[5] = enc(2, 0, 1 << 4);
        imem[6] = enc(15, 0, 0);
        iwait = 0; dwait = 0;
        do_reset();
        exec_and_check("carry_ldi0");
        exec_and_check("carry_ldi1");
        exec_and_check("carry_sub");
        chk_cnt++;
        if (o_reg0 !== 16'hFFFF || o_flags !== 2'b10)
            $display("FAIL carry_borrow: got r0=%h flags=%b expected ffff/10", o_reg0, o_flags);
        else pass_cnt++;
        exec_and_check("carry_add");
        chk_cnt++;
        if (o_reg0 !== 16'h0000 || o_flags !== 2'b11)
            $display("FAIL carry_wrap: got r0=%h flags=%b expected 0000/11", o_reg0, o_flags);
        else pass_cnt++;
        exec_and_check("carry_shr");
        chk_cnt++;
        if (o_flags !== 2'b11) $display("FAIL carry_shr_flags: got %b expected 11", o_flags); else pass_cnt++;
        exec_and_check("carry_mov");
        exec_and_check("carry_halt");
    endtask

    task automatic test_branch();
        clear_imem();
        imem[0] = enc(1, 0, 7);
        imem[1] = enc(4, 0, 0);
        imem[2] = enc(12, 0, 1);
        imem[3] = enc(1, 2, 9);
        imem[4] = enc(15, 0, 0);
        iwait = 0; dwait = 0;
        do_reset();
        exec_and_check("br_ldi");
        exec_and_check("br_sub");
        exec_and_check("br_jz");
        chk_cnt++;
        if (o_ip !== 16'h0004) $display("FAIL br_taken_ip: got %h expected 0004", o_ip); else pass_cnt++;
        exec_and_check("br_halt");
        chk_cnt++;
        if (halted !== 1'b1 || o_ip !== 16'h0005)
            $display("FAIL br_halt_ip: got halted=%b ip=%h expected 1/0005", halted, o_ip);
        else pass_cnt++;
    endtask

    task automatic test_mem();
        clear_imem();
        for (int i = 0; i < 256; i++) begin
            dmem[i] = '0;
            m_dmem[i] = '0;
        end
        imem[0] = enc(1, 1, 8'h20);
        imem[1] = enc(1, 0, 8'hA5);
        imem[2] = enc(11, 0, 1 << 4);
        imem[3] = enc(1, 0, 0);
        imem[4] = enc(10, 0, 1 << 4);
        imem[5] = enc(15, 0, 0);
        iwait = 0; dwait = 0;
        do_reset();
        exec_and_check("mem_ldi1");
        exec_and_check("mem_ldi0");
        exec_and_check("mem_st");
        chk_cnt++;
        if (dmem[8'h20] !== 16'h00A5) $display("FAIL mem_st_data: got %h expected 00a5", dmem[8'h20]); else pass_cnt++;
        exec_and_check("mem_clr");
        exec_and_check("mem_ld");
        chk_cnt++;
        if (o_reg0 !== 16'h00A5) $display("FAIL mem_ld_r0: got %h expected 00a5", o_reg0); else pass_cnt++;
        exec_and_check("mem_halt");
    endtask

    task automatic test_wait_states();
        int ec;
        bit se;
        logic [31:0] sv;
        clear_imem();
        imem[0] = enc(1, 0, 5);
        imem[1] = enc(1, 1, 3);
        imem[2] = enc(3, 0, 1 << 4);
        imem[3] = enc(15, 0, 0);
        iwait = 3; dwait = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (imem_req !== 1'b1 || imem_addr !== 16'h0 || o_ip !== 16'h0)
                $display("FAIL wait_fetch_stable: got req=%b addr=%h ip=%h expected 1/0000/0000", imem_req, imem_addr, o_ip);
            else pass_cnt++;
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        chk_cnt++;
        if (o_state !== 2'd1 || o_ip !== 16'h0001)
            $display("FAIL wait_fetch_done: got state=%0d ip=%h expected 1/0001", o_state, o_ip);
        else pass_cnt++;
        @(posedge clk); #1;
        model_step(ec, se, sv);
        chk_cnt++;
        if (o_reg0 !== 16'(m_reg[0])) $display("FAIL wait_first_r0: got %h expected %h", o_reg0, 16'(m_reg[0]));
        else pass_cnt++;
        exec_and_check("wait_ldi1");
        exec_and_check("wait_add");
        exec_and_check("wait_halt");
        chk_cnt++;
        if (o_reg0 !== 16'h0008 || halted !== 1'b1)
            $display("FAIL wait_result: got r0=%h halted=%b expected 0008/1", o_reg0, halted);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_mem();
        int cyc;
        clear_imem();
        imem[0] = enc(1, 0, 3);
        imem[1] = enc(1, 1, 8'h10);
        imem[2] = enc(10, 2, 1 << 4);
        iwait = 0; dwait = 1000;
        do_reset();
        exec_and_check("rmem_ldi0");
        exec_and_check("rmem_ldi1");
        cyc = 0;
        while (cyc < 20 && o_state !== 2'd2) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        chk_cnt++;
        if (o_state !== 2'd2 || dmem_req !== 1'b1)
            $display("FAIL rmem_stalled: got state=%0d req=%b expected 2/1", o_state, dmem_req);
        else pass_cnt++;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_cnt++;
        if (dmem_req !== 1'b0 || o_state !== 2'd0 || o_ip !== 16'h0 || o_reg0 !== 16'h0)
            $display("FAIL rmem_abandon: got req=%b state=%0d ip=%h r0=%h expected 0/0/0000/0000",
                     dmem_req, o_state, o_ip, o_reg0);
        else pass_cnt++;
        clear_imem();
        imem[0] = enc(2, 0, 1 << 4);
        imem[1] = enc(2, 0, 2 << 4);
        imem[2] = enc(1, 5, 1);
        imem[3] = enc(2, 0, 1 << 4);
        imem[4] = enc(15, 0, 0);
        dwait = 0;
        do_reset();
        exec_and_check("rmem_mov_r1");
        exec_and_check("rmem_mov_r2");
        chk_cnt++;
        if (o_reg0 !== 16'h0) $display("FAIL rmem_r2_unwritten: got %h expected 0000", o_reg0); else pass_cnt++;
        exec_and_check("rmem_ldi_r5");
        exec_and_check("rmem_mov_alias");
        chk_cnt++;
        if (o_reg0 !== 16'h0001) $display("FAIL rmem_reg_alias: got %h expected 0001", o_reg0); else pass_cnt++;
        exec_and_check("rmem_halt");
    endtask

    task automatic test_random();
        int op, n;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i++) begin
                op = $urandom_range(0, 15);
                if (op == 15 && $urandom_range(0, 3) != 0) op = 1;
                imem[i] = {4'(op), 12'($urandom)};
                dmem[i] = 16'($urandom);
                m_dmem[i] = dmem[i];
            end
            iwait = $urandom_range(0, 2);
            dwait = $urandom_range(0, 2);
            do_reset();
            n = 0;
            while (n < 50 && !m_halt) begin
                exec_and_check($sformatf("rand%0d_i%0d", p, n));
                n++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_branch();
        test_mem();
        test_wait_states();
        test_reset_in_mem();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multicycle CPU core: the next generation of our single-accumulator CPU, with configurable datapath width, register count and address width. It adds Z/C flags, relative branches, HALT, and req/ack handshakes to external instruction and data memories, so wait-state memories stall the core. It sits at the top of the processor hierarchy and exposes observer outputs for bench and board debug.

## Interface
- DW, 16, datapath/register width; legal 8..32
- NREG, 4, number of general registers; power of 2, 2..16
- AW, 16, instruction and data address width; legal 8..16
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  AW  fetch address (= ip)
- imem_rdata  in  16  instruction word
- imem_ack  in  1  fetch complete; rdata valid this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  AW  data address
- dmem_wdata  out  DW  store data
- dmem_rdata  in  DW  load data
- dmem_ack  in  1  data access complete
- o_ip  out  AW, o_ir  out  16, o_reg0  out  DW, o_flags  out  2 ({C,Z}), o_state  out  2, halted  out  1 — observers

## Operation
- Encoding: op=ir[15:12], rd=ir[11:8], rs=ir[7:4], imm8=ir[7:0]. Register index uses its low log2(NREG) bits; the upper bits are ignored.
- Opcodes:
  - 0 NOP
  - 1 LDI: rd=zext(imm8)
  - 2 MOV: rd=rs
  - 3 ADD, 4 SUB (rd=rd−rs), 5 AND, 6 OR, 7 XOR: rd=rd op rs
  - 8 SHL, 9 SHR: rd shifted by 1, zero fill
  - A LD: rd=mem[rs]
  - B ST: mem[rs]=rd
  - C JZ, D JC, E JMP: conditional/unconditional relative branch
  - F HALT
- Flags are written only by ops 3–9. Z=(result==0).
  - C = carry-out for ADD, borrow (rd<rs unsigned) for SUB, the bit shifted out for SHL/SHR, 0 for AND/OR/XOR.
- Arithmetic is modulo 2^DW. Data address = low AW bits of rs, zero-extended if DW<AW.
- Branch target = (address of branch + 1 + sext(imm8)) mod 2^AW. A not-taken branch falls through. ip wraps 2^AW−1 → 0.
- FSM states: FETCH=0, EXEC=1, MEM=2, HALT=3.
  - FETCH: imem_req=1. On imem_ack, latch ir←imem_rdata, ip←ip+1, go to EXEC.
  - EXEC: NOP/LDI/MOV/ALU/branch complete and go to FETCH. LD/ST go to MEM. HALT goes to HALT.
  - MEM: dmem_req=1, dmem_we=(op==ST), addr/wdata driven from registers. On dmem_ack, LD writes rd←dmem_rdata; then go to FETCH.
  - HALT: no requests, halted=1. Only reset leaves this state.
- Handshake: req is a decode of the state and stays high until ack is sampled high. Address, we and wdata are stable while req is high. ack with req low is ignored. Ack in the same cycle as req is legal (zero wait).

## Timing
- Reset values: state=FETCH, ip=0, ir=0, all registers 0, flags 0, halted=0, dmem_req=0.
  - imem_req=1 with imem_addr=0 while reset is held; acks during reset are ignored.
- Zero-wait latency: 2 cycles per non-memory instruction, 3 cycles for LD/ST. Each wait cycle adds 1.
- Register, flag and ip updates are visible on the edge ending EXEC (or MEM for LD). An ALU op reading the register written by the previous instruction sees the new value.
- Reset during MEM or FETCH abandons the access: on the next cycle, dmem_req=0 and the state is FETCH at ip 0. No register write occurs.
- ST writes memory only via the external ack; the core holds no write buffer.

## Test plan
- DW=16, zero-wait. Program LDI r0,5; LDI r1,3; ADD r0,r1; HALT -> r0=8, o_flags=00, halted rises 8 cycles after reset release, o_ip=4, no further imem_req.
- DW=8. Program LDI r0,0xFF; LDI r1,1; ADD r0,r1 -> r0=0x00, Z=1, C=1. Then SHR r1 -> r1=0, C=1, Z=1.
- Program LDI r0,7; SUB r0,r0; JZ +1; LDI r2,9; HALT -> Z=1, branch taken, r2 stays 0, halted at ip=5.
- Program LDI r1,0x20; LDI r0,0xA5; ST r0,[r1]; LDI r0,0; LD r0,[r1], with a memory model:
  - ST cycle shows dmem_we=1, addr=0x20, wdata=0xA5.
  - Final r0=0xA5.
- Wait states: imem_ack delayed 3 cycles per fetch -> imem_addr/req are stable over all 4 cycles, ip does not advance before ack, and the instruction count and results equal the zero-wait run.
- Reset asserted in MEM with dmem_ack held low -> next cycle dmem_req=0, state=FETCH, ip=0, all registers 0. NREG=4: LDI r5,1 writes r1.
